// File: rtl/instr_mem_loader.sv
// Writable instruction memory for the soft CPU, filled at run time from a byte stream.
// Fetches are registered (1-cycle latency) and stalled while a load is in progress.
`timescale 1ns/1ps
module instr_mem_loader #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 64,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  input  logic                  iFetch,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oInstructionValid,
  output logic                  oBusy,
  input  logic                  iLoadStart,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadByteValid,
  output logic                  oLoadDone,
  output logic                  oLoadError
);
  localparam int BPW = (DATA_WIDTH + 7) / 8;
  localparam int PW  = $clog2(DEPTH + 1);
  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_vmap;
  logic [PW-1:0]         r_ptr;
  logic [BCW-1:0]        r_bcnt;
  logic [7:0]            r_nlo;
  logic [15:0]           r_n;
  logic [DATA_WIDTH-1:0] r_asm, w_word, r_instr;
  logic                  r_ivalid;
  logic                  w_start, w_last_byte, w_we, w_last_word, w_fetch, w_hit;
  logic [16:0]           w_hdr_n;
  logic [AIW-1:0]        w_aidx, w_widx;

  assign w_start     = (r_state == S_IDLE) && iLoadStart;
  assign w_last_byte = (int'(r_bcnt) == BPW - 1);
  assign w_we        = (r_state == S_DATA) && iLoadByteValid && w_last_byte;
  assign w_last_word = (17'(r_ptr) + 17'd1) == {1'b0, r_n};
  assign w_hdr_n     = {1'b0, iLoadByte, r_nlo};
  assign w_widx      = r_ptr[AIW-1:0];
  assign w_aidx      = iAddress[AIW-1:0];
  // A fetch coinciding with a load start is dropped.
  assign w_fetch     = (r_state == S_IDLE) && iFetch && !iLoadStart;
  assign w_hit       = (32'(iAddress) < 32'(DEPTH)) && r_vmap[w_aidx];

  // Drop the incoming byte into its lane; bits past DATA_WIDTH fall away.
  always_comb begin
    w_word = r_asm;
    for (int j = 0; j < DATA_WIDTH; j++)
      if (j / 8 == int'(r_bcnt)) w_word[j] = iLoadByte[j % 8];
  end

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (iLoadStart) w_next = S_HDR0;
      S_HDR0: if (iLoadByteValid) w_next = S_HDR1;
      S_HDR1: if (iLoadByteValid)
                w_next = (w_hdr_n == 17'd0 || w_hdr_n > 17'(DEPTH)) ? S_ERR : S_DATA;
      S_DATA: if (w_we && w_last_word) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy      = (r_state != S_IDLE);
    oLoadDone  = (r_state == S_DONE);
    oLoadError = (r_state == S_ERR);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_vmap   <= '0;
      r_ptr    <= '0;
      r_bcnt   <= '0;
      r_nlo    <= '0;
      r_n      <= '0;
      r_asm    <= '0;
      r_instr  <= DEFAULT_WORD;
      r_ivalid <= 1'b0;
    end else begin
      if (w_start) begin
        r_vmap <= '0;
        r_ptr  <= '0;
        r_bcnt <= '0;
      end
      if (r_state == S_HDR0 && iLoadByteValid) r_nlo <= iLoadByte;
      if (r_state == S_HDR1 && iLoadByteValid) r_n   <= {iLoadByte, r_nlo};
      if (r_state == S_DATA && iLoadByteValid) begin
        r_asm  <= w_word;
        r_bcnt <= w_last_byte ? '0 : BCW'(r_bcnt + 1'b1);
        if (w_we) begin
          r_vmap[w_widx] <= 1'b1;
          r_ptr          <= r_ptr + 1'b1;
        end
      end
      r_ivalid <= w_fetch;
      if (w_fetch) r_instr <= w_hit ? r_mem[w_aidx] : DEFAULT_WORD;
    end
  end

  always_ff @(posedge Clock)
    if (w_we) r_mem[w_widx] <= w_word;

  assign oInstruction      = r_instr;
  assign oInstructionValid = r_ivalid;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a 28-bit/64-word instance and a 16-bit/8-word instance.
`timescale 1ns/1ps
module tb_instr_mem_loader;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_addr = '0;
  logic        a_fetch = 0, a_start = 0, a_bv = 0;
  logic [7:0]  a_byte = '0;
  logic [27:0] a_instr;
  logic        a_ivld, a_busy, a_done, a_err;

  logic [7:0]  b_addr = '0;
  logic        b_fetch = 0, b_start = 0, b_bv = 0;
  logic [7:0]  b_byte = '0;
  logic [15:0] b_instr;
  logic        b_ivld, b_busy, b_done, b_err;

  instr_mem_loader dut_a (
    .Clock(clk), .Reset(rst), .iAddress(a_addr), .iFetch(a_fetch),
    .oInstruction(a_instr), .oInstructionValid(a_ivld), .oBusy(a_busy),
    .iLoadStart(a_start), .iLoadByte(a_byte), .iLoadByteValid(a_bv),
    .oLoadDone(a_done), .oLoadError(a_err));

  instr_mem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(8), .DEFAULT_WORD(16'h00AA)) dut_b (
    .Clock(clk), .Reset(rst), .iAddress(b_addr), .iFetch(b_fetch),
    .oInstruction(b_instr), .oInstructionValid(b_ivld), .oBusy(b_busy),
    .iLoadStart(b_start), .iLoadByte(b_byte), .iLoadByteValid(b_bv),
    .oLoadDone(b_done), .oLoadError(b_err));

  int total = 0, bad = 0;

  typedef struct { int phase; logic [15:0] addr; logic [27:0] exp; } vec_t;
  vec_t vt[$];
  logic [7:0] stream2 [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_send(input logic [7:0] b);
    a_byte = b; a_bv = 1'b1; tick(); a_bv = 1'b0;
  endtask

  task automatic a_begin();
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_busy_rise", {31'd0, a_busy}, 32'd1);
  endtask

  task automatic a_load2();
    a_begin();
    for (int i = 0; i < 10; i++) begin
      a_send(stream2[i]);
      if (i < 9) check($sformatf("a_done_early_%0d", i), {31'd0, a_done}, 32'd0);
    end
    check("a_done_pulse", {30'd0, a_done, a_busy}, 32'd3);
    tick();
    check("a_done_clear", {30'd0, a_done, a_busy}, 32'd0);
  endtask

  task automatic run_phase(input int p);
    foreach (vt[i]) if (vt[i].phase == p) begin
      a_addr = vt[i].addr; a_fetch = 1'b1; tick(); a_fetch = 1'b0;
      check($sformatf("fetch_p%0d_a%0d", p, vt[i].addr),
            {a_ivld, 3'b0, a_instr}, {1'b1, 3'b0, vt[i].exp});
    end
  endtask

  task automatic b_send(input logic [7:0] b);
    b_byte = b; b_bv = 1'b1; tick(); b_bv = 1'b0;
  endtask

  task automatic b_fetch_chk(input logic [7:0] addr, input logic [15:0] exp);
    b_addr = addr; b_fetch = 1'b1; tick(); b_fetch = 1'b0;
    check($sformatf("b_fetch_a%0d", addr), {15'd0, b_ivld, b_instr}, {15'd0, 1'b1, exp});
  endtask

  initial begin
    stream2 = '{8'h02, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01, 8'hF0, 8'hDE, 8'hBC, 8'h0A};
    vt.push_back('{0, 16'd0,   28'h00000AA});
    vt.push_back('{0, 16'd5,   28'h00000AA});
    vt.push_back('{0, 16'd100, 28'h00000AA});
    vt.push_back('{1, 16'd0,   28'h1234567});
    vt.push_back('{1, 16'd1,   28'hABCDEF0});
    vt.push_back('{1, 16'd2,   28'h00000AA});
    vt.push_back('{2, 16'd0,   28'h00000AA});
    vt.push_back('{2, 16'd1,   28'h00000AA});
    vt.push_back('{2, 16'd63,  28'h00000AA});
    vt.push_back('{2, 16'd64,  28'h00000AA});
    vt.push_back('{3, 16'd0,   28'h00000AA});

    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_instr", {4'd0, a_instr}, 32'h00000AA);
    check("reset_flags", {28'd0, a_ivld, a_busy, a_done, a_err}, 32'd0);
    run_phase(0);

    a_load2();
    run_phase(1);

    // Count 65 exceeds DEPTH and must abort; the bitmap was cleared on entry.
    a_begin();
    a_send(8'h41);
    a_send(8'h00);
    check("a_err_pulse", {30'd0, a_err, a_done}, 32'd2);
    tick();
    check("a_err_clear", {30'd0, a_err, a_busy}, 32'd0);
    run_phase(2);

    a_load2();
    begin
      logic [15:0] seq [4];
      logic [27:0] exp [4];
      seq = '{16'd0, 16'd1, 16'd0, 16'd1};
      exp = '{28'h1234567, 28'hABCDEF0, 28'h1234567, 28'hABCDEF0};
      a_fetch = 1'b1;
      for (int i = 0; i < 4; i++) begin
        a_addr = seq[i]; tick();
        check($sformatf("b2b_%0d", i), {a_ivld, 3'b0, a_instr}, {1'b1, 3'b0, exp[i]});
      end
    end
    a_addr = 16'd0; a_start = 1'b1; tick();
    a_start = 1'b0; a_fetch = 1'b0;
    check("start_fetch_drop", {a_ivld, a_busy, 2'b0, a_instr}, {1'b0, 1'b1, 2'b0, 28'hABCDEF0});

    // Abort a 1-word load with reset after three data bytes.
    a_send(8'h01); a_send(8'h00);
    a_send(8'h11); a_send(8'h22); a_send(8'h33);
    rst = 1'b1; #1;
    check("rst_mid_flags", {29'd0, a_busy, a_done, a_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_after", {29'd0, a_busy, a_done, a_err}, 32'd0);
    run_phase(3);

    b_start = 1'b1; tick(); b_start = 1'b0;
    b_send(8'h01); b_send(8'h00); b_send(8'h34); b_send(8'h12);
    check("b_done_pulse", {30'd0, b_done, b_err}, 32'd2);
    tick();
    check("b_idle", {31'd0, b_busy}, 32'd0);
    b_fetch_chk(8'd0, 16'h1234);
    b_fetch_chk(8'd1, 16'h00AA);
    b_fetch_chk(8'd200, 16'h00AA);
    b_start = 1'b1; tick(); b_start = 1'b0;
    b_send(8'h09); b_send(8'h00);
    check("b_err_n9", {30'd0, b_err, b_done}, 32'd2);
    tick();
    check("b_err_idle", {30'd0, b_err, b_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
